// File: rtl/seq_adder.sv
// Chunk-serial adder: sum/co = a+b+ci, CHUNK bits per cycle (optional signed ovf via SEQ_ADDER_OVF_EN).
// Latency: out_valid rises WIDTH/CHUNK edges after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           st_q;
    state_t           st_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [31:0]      base;
    logic [CHUNK:0]   chunk_sum;
    logic             last;

    assign base      = 32'(cnt_q) * CHUNK;
    assign chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry_q};
    assign last      = (cnt_q == CW'(N - 1));

    always_comb begin
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (st_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) st_d = RUN;
            end
            RUN: begin
                if (last) st_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            co      <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            st_q <= st_d;
            case (st_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry_q            <= chunk_sum[CHUNK];
                    cnt_q              <= cnt_q + CW'(1);
                    if (last) begin
                        co <= chunk_sum[CHUNK];
`ifdef SEQ_ADDER_OVF_EN
                        // carry into MSB recovered as a^b^s at the MSB
                        ovf <= a_q[WIDTH-1] ^ b_q[WIDTH-1]
                             ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: vector table, random ops against an arithmetic model,
// abort-by-reset and single/bit-serial 8-bit configurations.
module tb_seq_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        in_valid, in_ready, ci, out_valid, out_ready, co;
    logic [15:0] a, b, sum;

    logic        in_valid8, ci8, out_ready8;
    logic [7:0]  a8, b8;
    logic        in_ready8a, out_valid8a, co8a;
    logic        in_ready8b, out_valid8b, co8b;
    logic [7:0]  sum8a, sum8b;
`ifdef SEQ_ADDER_OVF_EN
    logic        ovf, ovf8a, ovf8b;
`endif

    seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    seq_adder #(.WIDTH(8), .CHUNK(8)) dut8a (
        .clk(clk), .resetN(resetN), .in_valid(in_valid8), .in_ready(in_ready8a),
        .a(a8), .b(b8), .ci(ci8), .out_valid(out_valid8a), .out_ready(out_ready8),
        .sum(sum8a), .co(co8a)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf8a)
`endif
    );

    seq_adder #(.WIDTH(8), .CHUNK(1)) dut8b (
        .clk(clk), .resetN(resetN), .in_valid(in_valid8), .in_ready(in_ready8b),
        .a(a8), .b(b8), .ci(ci8), .out_valid(out_valid8b), .out_ready(out_ready8),
        .sum(sum8b), .co(co8b)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf8b)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ovf;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    // Starts and ends #1 after a rising edge with the DUT in IDLE.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                         input int hold, input logic [15:0] es, input logic eco,
                         input logic eovf, input string tag);
        int lat;
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        a = ta; b = tb_; ci = tci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
        chk({tag, ".in_ready_run"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".co"}, co, eco);
`ifdef SEQ_ADDER_OVF_EN
        chk({tag, ".ovf"}, ovf, eovf);
`else
        if (eovf === 1'bx) $display("note: unknown ovf expectation");
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom);
            chk({tag, ".hold_state"}, {out_valid, in_ready}, 2'b10);
            chk({tag, ".hold_res"}, {co, sum}, {eco, es});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".idle_after"}, {out_valid, in_ready}, 2'b01);
        chk({tag, ".idle_res"}, {co, sum}, {eco, es});
    endtask

    initial begin
        int unsigned tot;
        int          st;
        logic [15:0] ra, rb;
        logic        rci, eovf;
        int          lat_a, lat_b, quiet;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 10};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0};
        vecs[4] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 2};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 0};

        resetN = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.state", {out_valid, in_ready}, 2'b01);
        chk("reset.res", {co, sum}, 17'h0);
        chk("reset.8", {out_valid8a, in_ready8a, out_valid8b, in_ready8b}, 4'b0101);
        resetN = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].hold,
                  vecs[i].s, vecs[i].co, vecs[i].ovf, $sformatf("vec%0d", i));

        for (int n = 0; n < 30; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rci = 1'($urandom);
            tot  = 32'(ra) + 32'(rb) + 32'(rci);
            st   = int'($signed(ra)) + int'($signed(rb)) + int'(rci);
            eovf = (st > 32767) || (st < -32768);
            do_op(ra, rb, rci, int'($urandom_range(0, 3)), tot[15:0], tot[16], eovf,
                  $sformatf("rnd%0d", n));
        end

        // Abort an operation by reset in its second RUN cycle.
        a = 16'h1234; b = 16'h4321; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        chk("abort.state", {out_valid, in_ready}, 2'b01);
        chk("abort.res", {co, sum}, 17'h0);
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) quiet++;
        end
        chk("abort.no_out_valid", quiet, 0);
        do_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, "after_abort");

        // 8-bit: single-chunk and bit-serial configurations.
        a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        lat_a = -1; lat_b = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (out_valid8a && lat_a < 0) lat_a = e;
            if (out_valid8b && lat_b < 0) lat_b = e;
        end
        chk("w8c8.latency", lat_a, 1);
        chk("w8c1.latency", lat_b, 8);
        chk("w8c8.res", {co8a, sum8a}, 9'h100);
        chk("w8c1.res", {co8b, sum8b}, 9'h100);
`ifdef SEQ_ADDER_OVF_EN
        chk("w8.ovf", {ovf8a, ovf8b}, 2'b00);
`endif
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("w8.idle", {out_valid8a, in_ready8a, out_valid8b, in_ready8b}, 4'b0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
